ss_magn_limit_sched: RTL and testbench
======================================

Name: ss_magn_limit_sched

Overview:
- Epoch scheduler and limit configurator for a bank of N_LANE stochastic magnitude pulse-stretcher lanes.
- Sequences each evaluation epoch: one-cycle lane clear, a counting run of EPOCH_LEN cycles, then a limit update.
- Measures each lane's output-pulse density and nudges that lane's 8-bit LIMIT toward a programmed target density.
- Sits between the network control FSM (START/DONE handshake) and the stretcher lanes (LANE_INIT, LIMIT bus, OUT taps).

Parameters:
- N_LANE, 4: number of stretcher lanes controlled.
- CNT_W, 12: width of the epoch-length counter and per-lane ones counters.
- LIMIT_INIT, 5: LIMIT value loaded into every lane at reset.

Ports:
- CLK  input  1  system clock, rising edge.
- INIT  input  1  synchronous active-high reset.
- START  input  1  request one epoch; sampled only in IDLE.
- CONT  input  1  when high at UPDATE, chain straight into the next epoch.
- EPOCH_LEN  input  CNT_W  RUN cycles per epoch; latched in CLR.
- TARGET  input  CNT_W  desired ones count per epoch; sampled in UPDATE.
- TOL  input  CNT_W  dead-band half-width; sampled in UPDATE.
- LANE_OUT  input  N_LANE  OUT taps of the stretcher lanes.
- LANE_INIT  output  N_LANE  per-lane clear to the stretchers (all bits identical).
- LIMIT  output  8*N_LANE  packed per-lane limits; lane i is bits [8i+7:8i].
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle pulse, high during the UPDATE cycle.

Behaviour:
- Reset (INIT high at a CLK edge, synchronous):
  - state goes to IDLE; all LIMIT lanes load LIMIT_INIT; counters clear.
  - DONE and BUSY are 0.
  - LANE_INIT = all ones combinationally while INIT is high, so the stretchers clear in the same cycle.
  - INIT mid-epoch aborts the epoch; no LIMIT update occurs.
- States:
  - IDLE: START=1 goes to CLR; otherwise stay.
  - CLR (1 cycle): LANE_INIT all ones; ones counters to 0; latch EPOCH_LEN, with a value of 0 replaced by 1; epoch counter to 0. Go to RUN.
  - RUN: each cycle, ones counter i increments when LANE_OUT[i]=1, saturating at all ones. The epoch counter increments, and the state goes to UPDATE after exactly the latched-length number of RUN cycles.
  - UPDATE (1 cycle): DONE=1. Per lane, with count c:
    - c + TOL < TARGET: LIMIT+1, saturating at 255.
    - c > TARGET + TOL: LIMIT-1, saturating at 0.
    - otherwise hold.
    - Compare at CNT_W+1 bits so the sums cannot wrap.
    - New LIMIT is visible the cycle after UPDATE.
    - Next state is CLR if CONT=1, else IDLE.
- Latency: START high in IDLE at cycle t gives CLR at t+1, RUN at t+2 .. t+1+L, and DONE at t+2+L (L = latched epoch length).
- Ignored inputs: START outside IDLE is ignored; LANE_OUT outside RUN is ignored.
- LANE_INIT is 0 in every state except CLR, and during INIT.
- EPOCH_LEN changes during RUN have no effect.

Optional Feature:
- Macro: SS_MAGN_SCHED_STATUS_EN.
- Defined:
  - Adds output LIMIT_SAT [N_LANE].
  - Bit i is registered in UPDATE: set when lane i wanted to step beyond 0 or 255 and was clamped, cleared otherwise.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=0, CLR=1, RUN=2, UPDATE=3.
  - LIMIT width constant (8) and the 255 saturation constant.
- Natural sub-module: ss_lane_density_cnt, one per lane. It contains the saturating ones counter, the dead-band compare and the saturating LIMIT step; generated N_LANE times.

Test Plan:
- Basic update: N_LANE=2, EPOCH_LEN=16, TARGET=8, TOL=1; lane0 held 1, lane1 held 0. Required: DONE 18 cycles after START; LIMIT0 5->4; LIMIT1 5->6.
- Dead band: lane0 pattern 1010... for 16 cycles (c=8) with TARGET=8, TOL=1. Required: LIMIT0 stays 5 and DONE still pulses exactly once.
- Saturation: preload by repeated epochs until LIMIT1=255 with lane1=0, and drive LIMIT0 to 0 with lane0=1. Required: both hold at 255 and 0; LIMIT_SAT=2'b11 when the macro is defined.
- Zero length and chaining: EPOCH_LEN=0 with CONT=1. Required: exactly 1 RUN cycle; DONE every 3 cycles (CLR, RUN, UPDATE); LANE_INIT high exactly on each CLR cycle.
- Reset mid-RUN: INIT high at RUN cycle 7 of 16. Required: next cycle IDLE; LIMIT=LIMIT_INIT; DONE never asserted; LANE_INIT all ones while INIT is high.
- START while BUSY: pulse START during RUN. Required: no effect on timing or counts; returns to IDLE after UPDATE when CONT=0.

Source files
------------

// File: rtl/ss_magn_limit_sched_pkg.sv
// Shared state encoding and LIMIT constants for the magnitude-limit epoch scheduler.
package ss_magn_limit_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_RUN    = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam int                 LIMIT_W   = 8;
  localparam logic [LIMIT_W-1:0] LIMIT_MAX = 8'd255;

endpackage

// File: rtl/ss_lane_density_cnt.sv
// One lane: saturating ones counter, dead-band compare and saturating LIMIT step.
// Optional clamp flag output when SS_MAGN_SCHED_STATUS_EN is defined.
module ss_lane_density_cnt
  import ss_magn_limit_sched_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int LIMIT_INIT = 5
) (
  input  logic               clk_i,
  input  logic               init_i,
  input  logic               clr_i,
  input  logic               run_i,
  input  logic               upd_i,
  input  logic               lane_out_i,
  input  logic [CNT_W-1:0]   target_i,
  input  logic [CNT_W-1:0]   tol_i,
`ifdef SS_MAGN_SCHED_STATUS_EN
  output logic               sat_o,
`endif
  output logic [LIMIT_W-1:0] limit_o
);

  localparam logic [LIMIT_W-1:0] LIMIT_RST = LIMIT_W'(LIMIT_INIT);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic [CNT_W:0]     lo_sum, hi_sum;
  logic               want_inc, want_dec;

  // One extra bit so c+TOL and TARGET+TOL never wrap.
  assign lo_sum   = {1'b0, cnt_q} + {1'b0, tol_i};
  assign hi_sum   = {1'b0, target_i} + {1'b0, tol_i};
  assign want_inc = lo_sum < {1'b0, target_i};
  assign want_dec = {1'b0, cnt_q} > hi_sum;

  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && lane_out_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (upd_i) begin
      if (want_inc && (limit_q != LIMIT_MAX)) begin
        limit_d = limit_q + 1'b1;
      end else if (want_dec && (limit_q != '0)) begin
        limit_d = limit_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      cnt_q   <= '0;
      limit_q <= LIMIT_RST;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign limit_o = limit_q;

`ifdef SS_MAGN_SCHED_STATUS_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (upd_i) begin
      sat_d = (want_inc && (limit_q == LIMIT_MAX)) || (want_dec && (limit_q == '0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`endif

endmodule

// File: rtl/ss_magn_limit_sched.sv
// Epoch scheduler (IDLE -> CLR -> RUN x L -> UPDATE) driving N_LANE density/limit lanes.
// Define SS_MAGN_SCHED_STATUS_EN to add the per-lane limit_sat_o clamp flags.
module ss_magn_limit_sched
  import ss_magn_limit_sched_pkg::*;
#(
  parameter int N_LANE     = 4,
  parameter int CNT_W      = 12,
  parameter int LIMIT_INIT = 5
) (
  input  logic                      clk_i,
  input  logic                      init_i,
  input  logic                      start_i,
  input  logic                      cont_i,
  input  logic [CNT_W-1:0]          epoch_len_i,
  input  logic [CNT_W-1:0]          target_i,
  input  logic [CNT_W-1:0]          tol_i,
  input  logic [N_LANE-1:0]         lane_out_i,
  output logic [N_LANE-1:0]         lane_init_o,
  output logic [LIMIT_W*N_LANE-1:0] limit_o,
`ifdef SS_MAGN_SCHED_STATUS_EN
  output logic [N_LANE-1:0]         limit_sat_o,
`endif
  output logic                      busy_o,
  output logic                      done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] ep_cnt_q, ep_cnt_d;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ep_cnt_d = ep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLR;
      end
      ST_CLR: begin
        // A zero length would never terminate RUN; treat it as one cycle.
        len_d    = (epoch_len_i == '0) ? CNT_W'(1) : epoch_len_i;
        ep_cnt_d = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        ep_cnt_d = ep_cnt_q + 1'b1;
        if (ep_cnt_d == len_q) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = cont_i ? ST_CLR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      ep_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ep_cnt_q <= ep_cnt_d;
    end
  end

  assign lane_init_o = {N_LANE{init_i || (state_q == ST_CLR)}};
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_UPDATE);

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    ss_lane_density_cnt #(
      .CNT_W      (CNT_W),
      .LIMIT_INIT (LIMIT_INIT)
    ) u_lane (
      .clk_i      (clk_i),
      .init_i     (init_i),
      .clr_i      (state_q == ST_CLR),
      .run_i      (state_q == ST_RUN),
      .upd_i      (state_q == ST_UPDATE),
      .lane_out_i (lane_out_i[i]),
      .target_i   (target_i),
      .tol_i      (tol_i),
`ifdef SS_MAGN_SCHED_STATUS_EN
      .sat_o      (limit_sat_o[i]),
`endif
      .limit_o    (limit_o[LIMIT_W*i +: LIMIT_W])
    );
  end

endmodule

// File: tb/tb_ss_magn_limit_sched.sv
// Self-checking bench for ss_magn_limit_sched with two lanes and a limit scoreboard.
module tb_ss_magn_limit_sched;

  localparam int N  = 2;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          init = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [CW-1:0] epoch_len = '0;
  logic [CW-1:0] target = '0;
  logic [CW-1:0] tol = '0;
  logic [N-1:0]  lane_out = '0;
  logic [N-1:0]  lane_init;
  logic [15:0]   limit;
  logic          busy;
  logic          done;
`ifdef SS_MAGN_SCHED_STATUS_EN
  logic [N-1:0]  limit_sat;
`endif

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l1;
    logic [1:0] sat;
  } exp_t;

  exp_t sb[$];
  int   m_lim[2];
  bit   m_sat[2];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ss_magn_limit_sched #(.N_LANE(N), .CNT_W(CW), .LIMIT_INIT(5)) dut (
    .clk_i       (clk),
    .init_i      (init),
    .start_i     (start),
    .cont_i      (cont),
    .epoch_len_i (epoch_len),
    .target_i    (target),
    .tol_i       (tol),
    .lane_out_i  (lane_out),
    .lane_init_o (lane_init),
    .limit_o     (limit),
`ifdef SS_MAGN_SCHED_STATUS_EN
    .limit_sat_o (limit_sat),
`endif
    .busy_o      (busy),
    .done_o      (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit pat_bit(input int pat, input int k);
    if (pat == 1) return 1'b1;
    if (pat == 2) return (k % 2) == 0;
    return 1'b0;
  endfunction

  // Reference LIMIT rule computed with wide ints so sums cannot wrap.
  task automatic model_lane(input int ln, input int c, input int tgt, input int tl);
    if (c + tl < tgt) begin
      m_sat[ln] = (m_lim[ln] == 255);
      if (m_lim[ln] != 255) m_lim[ln]++;
    end else if (c > tgt + tl) begin
      m_sat[ln] = (m_lim[ln] == 0);
      if (m_lim[ln] != 0) m_lim[ln]--;
    end else begin
      m_sat[ln] = 1'b0;
    end
  endtask

  // Entered at the negedge inside the CLR cycle; returns at the negedge after UPDATE.
  task automatic epoch_body(input int len, input int tgt, input int tl, input int p0,
                            input int p1, input bit cn, input bit poke, input int t_clr);
    int   L;
    int   c0;
    int   c1;
    exp_t e;
    L  = (len == 0) ? 1 : len;
    c0 = 0;
    c1 = 0;
    tests++;
    if (lane_init !== 2'b11 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL clr_state: lane_init=%b busy=%b done=%b, need 11/1/0", lane_init, busy, done);
    end
    lane_out = 2'b11;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      lane_out = {pat_bit(p1, k), pat_bit(p0, k)};
      c0 += int'(lane_out[0]);
      c1 += int'(lane_out[1]);
      if (poke && k == 1) begin
        start     = 1'b1;
        epoch_len = 12'd3;
      end else begin
        start = 1'b0;
      end
      target = 12'd4000;
      tests++;
      if (done !== 1'b0 || busy !== 1'b1 || lane_init !== 2'b00) begin
        fails++;
        $display("FAIL run_state k=%0d: done=%b busy=%b lane_init=%b, need 0/1/00", k, done, busy, lane_init);
      end
    end
    @(negedge clk);
    start    = 1'b0;
    lane_out = 2'b11;
    target   = CW'(tgt);
    tol      = CW'(tl);
    cont     = cn;
    tests++;
    if (done !== 1'b1 || cyc !== t_clr + 1 + L || lane_init !== 2'b00) begin
      fails++;
      $display("FAIL update_timing: done=%b cycle=%0d lane_init=%b, need 1 at cycle %0d, 00",
               done, cyc, lane_init, t_clr + 1 + L);
    end
    model_lane(0, c0, tgt, tl);
    model_lane(1, c1, tgt, tl);
    e.l0  = 8'(m_lim[0]);
    e.l1  = 8'(m_lim[1]);
    e.sat = {m_sat[1], m_sat[0]};
    sb.push_back(e);
    @(negedge clk);
    lane_out = 2'b00;
    cont     = 1'b0;
    e = sb.pop_front();
    tests++;
    if (limit !== {e.l1, e.l0}) begin
      fails++;
      $display("FAIL limit_update: got %h, need %h", limit, {e.l1, e.l0});
    end
`ifdef SS_MAGN_SCHED_STATUS_EN
    tests++;
    if (limit_sat !== e.sat) begin
      fails++;
      $display("FAIL limit_sat: got %b, need %b", limit_sat, e.sat);
    end
`endif
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_single_pulse: done=%b after UPDATE, need 0", done);
    end
    if (!cn) begin
      tests++;
      if (busy !== 1'b0 || lane_init !== 2'b00) begin
        fails++;
        $display("FAIL back_to_idle: busy=%b lane_init=%b, need 0/00", busy, lane_init);
      end
    end
  endtask

  task automatic start_epoch(input int len, input int tgt, input int tl, input int p0,
                             input int p1, input bit cn, input bit poke);
    int s;
    @(negedge clk);
    start     = 1'b1;
    epoch_len = CW'(len);
    s         = cyc;
    @(negedge clk);
    start = 1'b0;
    epoch_body(len, tgt, tl, p0, p1, cn, poke, s + 1);
  endtask

  task automatic test_reset();
    init = 1'b1;
    @(negedge clk);
    tests++;
    if (lane_init !== 2'b11) begin
      fails++;
      $display("FAIL reset_lane_init: got %b, need 11", lane_init);
    end
    @(negedge clk);
    init = 1'b0;
    m_lim = '{5, 5};
    m_sat = '{0, 0};
    @(negedge clk);
    tests++;
    if (limit !== 16'h0505 || busy !== 1'b0 || done !== 1'b0 || lane_init !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: limit=%h busy=%b done=%b lane_init=%b, need 0505/0/0/00",
               limit, busy, done, lane_init);
    end
  endtask

  task automatic test_basic();
    start_epoch(16, 8, 1, 1, 0, 1'b0, 1'b0);
    tests++;
    if (limit !== 16'h0604) begin
      fails++;
      $display("FAIL basic_limits: got %h, need 0604", limit);
    end
  endtask

  task automatic test_dead_band();
    start_epoch(16, 8, 1, 2, 0, 1'b0, 1'b0);
    tests++;
    if (limit[7:0] !== 8'd4) begin
      fails++;
      $display("FAIL dead_band_hold: lane0=%0d, need 4", limit[7:0]);
    end
  endtask

  task automatic test_zero_len_chain();
    start_epoch(0, 0, 0, 1, 2, 1'b1, 1'b0);
    epoch_body(0, 0, 0, 0, 1, 1'b1, 1'b0, cyc);
    epoch_body(0, 0, 0, 2, 2, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_saturation();
    start_epoch(2, 1, 0, 1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      epoch_body(2, 1, 0, 1, 0, i < 299, 1'b0, cyc);
    end
    tests++;
    if (limit !== 16'hFF00) begin
      fails++;
      $display("FAIL saturation_hold: got %h, need ff00", limit);
    end
`ifdef SS_MAGN_SCHED_STATUS_EN
    tests++;
    if (limit_sat !== 2'b11) begin
      fails++;
      $display("FAIL saturation_flags: got %b, need 11", limit_sat);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    start_epoch(16, 8, 1, 2, 1, 1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_while_busy_idle: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start     = 1'b1;
    epoch_len = 12'd16;
    target    = 12'd8;
    tol       = 12'd1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      lane_out = 2'b01;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL mid_run_done: done=%b at run cycle %0d, need 0", done, k + 1);
      end
    end
    init = 1'b1;
    #1;
    tests++;
    if (lane_init !== 2'b11) begin
      fails++;
      $display("FAIL init_lane_init_comb: got %b, need 11", lane_init);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || limit !== 16'h0505 || lane_init !== 2'b11) begin
      fails++;
      $display("FAIL mid_run_reset: busy=%b done=%b limit=%h lane_init=%b, need 0/0/0505/11",
               busy, done, limit, lane_init);
    end
    init     = 1'b0;
    lane_out = 2'b00;
    m_lim    = '{5, 5};
    m_sat    = '{0, 0};
    sb.delete();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || lane_init !== 2'b00 || limit !== 16'h0505) begin
      fails++;
      $display("FAIL after_reset_idle: busy=%b done=%b lane_init=%b limit=%h, need 0/0/00/0505",
               busy, done, lane_init, limit);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dead_band();
    test_zero_len_chain();
    test_start_while_busy();
    test_saturation();
    test_reset_mid_run();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
